// File: rtl/sd_boot_sequencer.sv
// rtl/sd_boot_sequencer.sv - SPI-mode SDHC init and CMD17 boot-block reader driving the microSD SPI byte engine
module sd_boot_sequencer #(
  parameter logic [2:0] SLOW_DIV       = 3'b100,
  parameter logic [2:0] FAST_DIV       = 3'b001,
  parameter int         DUMMY_REPS     = 2,
  parameter int         MAX_RETRY      = 8,
  parameter int         ACMD41_MAX     = 1023,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         ADDR_W         = 16
) (
  input  logic              spi_clk_i,
  input  logic              spi_rst_i,
  input  logic              start_i,
  input  logic [31:0]       start_block_i,
  input  logic [15:0]       num_blocks_i,
  output logic [47:0]       spi_data_o,
  output logic [8:0]        spi_statusreg_o,
  input  logic [2:0]        spi_flagreg_i,
  input  logic [7:0]        R1_i,
  input  logic [31:0]       spi_data_i,
  output logic [31:0]       word_o,
  output logic              word_valid_o,
  output logic [ADDR_W-1:0] word_addr_o,
  output logic              busy_o,
  output logic              boot_done_o,
  output logic              boot_err_o,
  output logic [2:0]        err_code_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      DUMMY_LAST = 4'(DUMMY_REPS - 1);
  localparam logic [3:0]      RETRY_LAST = 4'(MAX_RETRY - 1);
  localparam logic [9:0]      A_LAST     = 10'(ACMD41_MAX - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_DUMMY, S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_READ, S_DONE, S_ERROR
  } state_t;
  typedef enum logic [1:0] {XSTART, XWAIT_BUSY, XWAIT_DONE, XR1} xphase_t;

  state_t    st, st_n;
  xphase_t   ph, ph_n;
  logic [WD_W-1:0] wd;
  logic [3:0]  dcnt, retry;
  logic [9:0]  acnt;
  logic [15:0] blk_cnt;
  logic [8:0]  wcnt;
  logic [2:0]  div_q, err_n;
  logic        rd_q, ss_q, op_q, cw_q, cw_edge, in_xfer;
  logic        dcnt_inc, retry_inc, retry_clr, acnt_inc, a_fail, blk_inc, go_fast;
  logic [47:0] cmd_word;
  logic        unused_datawr;

  assign unused_datawr   = spi_flagreg_i[2];
  assign spi_statusreg_o = {1'b1, div_q, rd_q, 1'b0, 1'b1, ss_q, op_q};
  assign cw_edge         = spi_flagreg_i[0] & ~cw_q;
  assign in_xfer         = (st != S_IDLE) && (st != S_DONE) && (st != S_ERROR);

  always_comb begin
    case (st)
      S_CMD0:   cmd_word = 48'h400000000095;
      S_CMD8:   cmd_word = 48'h48000001AA87;
      S_CMD55:  cmd_word = 48'h770000000065;
      S_ACMD41: cmd_word = 48'h694000000077;
      S_READ:   cmd_word = {8'h51, start_block_i + {16'd0, blk_cnt}, 8'hFF};
      default:  cmd_word = 48'hFFFFFFFFFFFF;
    endcase
  end

  always_comb begin
    st_n = st;  ph_n = ph;  err_n = 3'd0;
    dcnt_inc = 1'b0;  retry_inc = 1'b0;  retry_clr = 1'b0;
    acnt_inc = 1'b0;  a_fail = 1'b0;  blk_inc = 1'b0;  go_fast = 1'b0;
    if (st == S_IDLE) begin
      if (start_i) begin st_n = S_DUMMY; ph_n = XSTART; end
    end else if (!in_xfer) begin
      st_n = S_IDLE;
    end else begin
      case (ph)
        XSTART:     ph_n = XWAIT_BUSY;
        XWAIT_BUSY: if (!spi_flagreg_i[1]) ph_n = XWAIT_DONE;
                    else if (wd == WD_LAST) begin st_n = S_ERROR; err_n = 3'd4; end
        XWAIT_DONE: if (spi_flagreg_i[1]) ph_n = XR1;
                    else if (wd == WD_LAST) begin st_n = S_ERROR; err_n = 3'd4; end
        default: begin
          ph_n = XSTART;
          case (st)
            S_DUMMY: begin
              dcnt_inc = 1'b1;
              if (dcnt == DUMMY_LAST) st_n = S_CMD0;
            end
            S_CMD0, S_CMD8: begin
              if (R1_i == 8'h01) begin
                st_n = (st == S_CMD0) ? S_CMD8 : S_CMD55;
                retry_clr = 1'b1;
              end else if (retry == RETRY_LAST) begin
                st_n  = S_ERROR;
                err_n = (st == S_CMD0) ? 3'd1 : 3'd2;
              end else retry_inc = 1'b1;
            end
            S_CMD55: if (R1_i == 8'h00 || R1_i == 8'h01) st_n = S_ACMD41;
                     else a_fail = 1'b1;
            S_ACMD41: if (R1_i == 8'h00) begin
                       go_fast = 1'b1;
                       st_n = (num_blocks_i == 16'd0) ? S_DONE : S_READ;
                     end else a_fail = 1'b1;
            default: begin
              if (wcnt != 9'd128) begin st_n = S_ERROR; err_n = 3'd5; end
              else begin
                blk_inc = 1'b1;
                if (blk_cnt + 16'd1 == num_blocks_i) st_n = S_DONE;
              end
            end
          endcase
          // A rejected CMD55 and a non-ready ACMD41 both burn one init iteration
          if (a_fail) begin
            if (acnt == A_LAST) begin st_n = S_ERROR; err_n = 3'd3; end
            else begin acnt_inc = 1'b1; st_n = S_CMD55; end
          end
        end
      endcase
    end
  end

  always_ff @(posedge spi_clk_i) begin
    if (spi_rst_i) begin
      st <= S_IDLE;  ph <= XSTART;  wd <= '0;
      dcnt <= '0;  retry <= '0;  acnt <= '0;  blk_cnt <= '0;  wcnt <= '0;
      spi_data_o <= 48'hFFFFFFFFFFFF;
      div_q <= SLOW_DIV;  rd_q <= 1'b0;  ss_q <= 1'b1;  op_q <= 1'b0;  cw_q <= 1'b0;
      word_o <= '0;  word_valid_o <= 1'b0;  word_addr_o <= '0;
      busy_o <= 1'b0;  boot_done_o <= 1'b0;  boot_err_o <= 1'b0;  err_code_o <= '0;
    end else begin
      st <= st_n;  ph <= ph_n;
      cw_q <= spi_flagreg_i[0];
      word_valid_o <= 1'b0;
      if (word_valid_o) word_addr_o <= word_addr_o + 1'b1;
      if (in_xfer) begin
        if (ph == XSTART) begin
          spi_data_o <= cmd_word;
          ss_q <= (st == S_DUMMY);
          rd_q <= (st == S_READ);
          op_q <= 1'b1;
          wd   <= '0;
          if (st == S_READ) wcnt <= '0;
        end else wd <= wd + 1'b1;
        if (ph == XWAIT_BUSY && !spi_flagreg_i[1]) op_q <= 1'b0;
      end
      if (st == S_READ && ph != XSTART && cw_edge) begin
        word_o <= spi_data_i;
        word_valid_o <= 1'b1;
        wcnt <= wcnt + 1'b1;
      end
      if (dcnt_inc)  dcnt <= dcnt + 1'b1;
      if (retry_inc) retry <= retry + 1'b1;
      if (retry_clr) retry <= '0;
      if (acnt_inc)  acnt <= acnt + 1'b1;
      if (blk_inc)   blk_cnt <= blk_cnt + 1'b1;
      if (go_fast)   div_q <= FAST_DIV;
      if (st == S_IDLE && start_i) begin
        dcnt <= '0;  retry <= '0;  acnt <= '0;  blk_cnt <= '0;  wcnt <= '0;
        div_q <= SLOW_DIV;  word_addr_o <= '0;  err_code_o <= '0;
        boot_done_o <= 1'b0;  boot_err_o <= 1'b0;  busy_o <= 1'b1;
      end
      if (st_n == S_DONE) begin
        boot_done_o <= 1'b1;  busy_o <= 1'b0;
      end
      if (st_n == S_ERROR) begin
        boot_err_o <= 1'b1;  err_code_o <= err_n;  busy_o <= 1'b0;  op_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sd_boot_sequencer.sv
// tb/tb_sd_boot_sequencer.sv - engine/card model driven bench for sd_boot_sequencer
module tb_sd_boot_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [31:0] start_block;
  logic [15:0] num_blocks;
  logic [47:0] spi_data;
  logic [8:0]  status;
  logic [2:0]  flags;
  logic [7:0]  r1;
  logic [31:0] sdata, word;
  logic        wv, busy, bdone, berr;
  logic [15:0] waddr;
  logic [2:0]  ecode;

  logic        t_start;
  logic [47:0] t_spi_data;
  logic [8:0]  t_status;
  logic [31:0] t_word;
  logic        t_wv, t_busy, t_bdone, t_berr;
  logic [15:0] t_waddr;
  logic [2:0]  t_ecode;

  sd_boot_sequencer dut (
    .spi_clk_i(clk), .spi_rst_i(rst), .start_i(start), .start_block_i(start_block),
    .num_blocks_i(num_blocks), .spi_data_o(spi_data), .spi_statusreg_o(status),
    .spi_flagreg_i(flags), .R1_i(r1), .spi_data_i(sdata), .word_o(word),
    .word_valid_o(wv), .word_addr_o(waddr), .busy_o(busy), .boot_done_o(bdone),
    .boot_err_o(berr), .err_code_o(ecode));

  sd_boot_sequencer #(.TIMEOUT_CYCLES(100)) t_dut (
    .spi_clk_i(clk), .spi_rst_i(rst), .start_i(t_start), .start_block_i(32'd0),
    .num_blocks_i(16'd1), .spi_data_o(t_spi_data), .spi_statusreg_o(t_status),
    .spi_flagreg_i(3'b000), .R1_i(8'h00), .spi_data_i(32'd0), .word_o(t_word),
    .word_valid_o(t_wv), .word_addr_o(t_waddr), .busy_o(t_busy), .boot_done_o(t_bdone),
    .boot_err_o(t_berr), .err_code_o(t_ecode));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] blk, input int idx);
    return blk * 32'h9E3779B1 + 32'(idx) * 32'h85EBCA6B + 32'h00001234;
  endfunction

  typedef struct {
    int          c0f;
    int          c8f;
    int          a1;
    logic [31:0] sb;
    int          nb;
    int          wpb;
    logic [2:0]  exp_code;
  } vec_t;

  // Card/engine behaviour knobs for the current run
  int c0f, c8f, a1, wpb, c0_seen, c8_seen, a_seen;
  logic [56:0] cmd_log[$];
  logic [47:0] got_words[$];
  bit          eng_busy;
  int          words_left, widx, dly;
  logic [31:0] cur_blk;

  always @(negedge clk) begin
    if (rst) begin
      eng_busy = 1'b0;  flags = 3'b010;  r1 = 8'hFF;  sdata = '0;
    end else begin
      if (wv) got_words.push_back({waddr, word});
      if (!eng_busy && status[0]) begin
        eng_busy = 1'b1;  flags[1] = 1'b0;
        cmd_log.push_back({status, spi_data});
        dly = 2;  widx = 0;  cur_blk = spi_data[39:8];
        words_left = status[4] ? wpb : 0;
        case (spi_data[47:40])
          8'h40: begin r1 = (c0_seen < c0f) ? 8'hFF : 8'h01; c0_seen++; end
          8'h48: begin r1 = (c8_seen < c8f) ? 8'h05 : 8'h01; c8_seen++; end
          8'h77: r1 = 8'h01;
          8'h69: begin r1 = (a_seen < a1) ? 8'h01 : 8'h00; a_seen++; end
          8'h51: r1 = 8'h00;
          default: r1 = 8'hFF;
        endcase
      end else if (eng_busy) begin
        if (flags[0]) flags[0] = 1'b0;
        else if (words_left > 0) begin
          sdata = word_of(cur_blk, widx);  widx++;  words_left--;  flags[0] = 1'b1;
        end else if (dly > 0) dly--;
        else begin flags[1] = 1'b1;  eng_busy = 1'b0; end
      end
    end
  end

  task automatic run_vec(input vec_t v, input string tag);
    logic [56:0] exp_log[$];
    logic [47:0] exp_words[$];
    logic [8:0]  st_slow_ss, st_slow, st_fast_rd;
    logic [2:0]  code;
    int n, cyc, mism, nwords;
    c0f = v.c0f;  c8f = v.c8f;  a1 = v.a1;  wpb = v.wpb;
    c0_seen = 0;  c8_seen = 0;  a_seen = 0;
    cmd_log.delete();  got_words.delete();
    start_block = v.sb;  num_blocks = 16'(v.nb);

    st_slow_ss = {1'b1, 3'b100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    st_slow    = {1'b1, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    st_fast_rd = {1'b1, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    code = 3'd0;  nwords = 0;
    for (int i = 0; i < 2; i++) exp_log.push_back({st_slow_ss, 48'hFFFFFFFFFFFF});
    n = (v.c0f >= 8) ? 8 : v.c0f + 1;
    for (int i = 0; i < n; i++) exp_log.push_back({st_slow, 48'h400000000095});
    if (v.c0f >= 8) code = 3'd1;
    if (code == 0) begin
      n = (v.c8f >= 8) ? 8 : v.c8f + 1;
      for (int i = 0; i < n; i++) exp_log.push_back({st_slow, 48'h48000001AA87});
      if (v.c8f >= 8) code = 3'd2;
    end
    if (code == 0) begin
      n = (v.a1 >= 1023) ? 1023 : v.a1 + 1;
      for (int i = 0; i < n; i++) begin
        exp_log.push_back({st_slow, 48'h770000000065});
        exp_log.push_back({st_slow, 48'h694000000077});
      end
      if (v.a1 >= 1023) code = 3'd3;
    end
    if (code == 0) begin
      for (int b = 0; b < v.nb; b++) begin
        logic [31:0] blk;
        blk = v.sb + 32'(b);
        exp_log.push_back({st_fast_rd, 8'h51, blk, 8'hFF});
        for (int w = 0; w < v.wpb; w++) begin
          exp_words.push_back({16'(nwords), word_of(blk, w)});
          nwords++;
        end
        if (v.wpb != 128) begin code = 3'd5; break; end
      end
    end

    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (!(bdone || berr) && cyc < 40000) begin @(negedge clk); cyc++; end
    repeat (2) @(negedge clk);

    check({tag, "_finished"}, (cyc < 40000), 1'b1);
    check({tag, "_model_code"}, code, v.exp_code);
    check({tag, "_boot_done"}, bdone, (v.exp_code == 3'd0));
    check({tag, "_boot_err"}, berr, (v.exp_code != 3'd0));
    if (v.exp_code != 3'd0) check({tag, "_err_code"}, ecode, v.exp_code);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_cmd_count"}, cmd_log.size(), exp_log.size());
    mism = -1;
    for (int i = 0; i < exp_log.size() && i < cmd_log.size(); i++)
      if (mism < 0 && cmd_log[i] !== exp_log[i]) mism = i;
    if (mism >= 0) check($sformatf("%s_cmd_%0d", tag, mism), cmd_log[mism], exp_log[mism]);
    else check({tag, "_cmd_seq"}, 1'b1, (cmd_log.size() == exp_log.size()));
    check({tag, "_word_count"}, got_words.size(), exp_words.size());
    mism = -1;
    for (int i = 0; i < exp_words.size() && i < got_words.size(); i++)
      if (mism < 0 && got_words[i] !== exp_words[i]) mism = i;
    if (mism >= 0) check($sformatf("%s_word_%0d", tag, mism), got_words[mism], exp_words[mism]);
    else check({tag, "_word_seq"}, 1'b1, (got_words.size() == exp_words.size()));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_spi_data"}, spi_data, 48'hFFFFFFFFFFFF);
    check({tag, "_status"}, status, {1'b1, 3'b100, 5'b00110});
    check({tag, "_outs"}, {word, wv, waddr, busy, bdone, berr, ecode}, '0);
  endtask

  vec_t tbl[8];

  initial begin
    int n, cyc;
    rst = 1'b1;  start = 1'b0;  t_start = 1'b0;
    start_block = '0;  num_blocks = '0;  wpb = 128;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    check("reset_t_status", t_status, {1'b1, 3'b100, 5'b00110});
    rst = 1'b0;

    tbl[0] = '{c0f: 0, c8f: 0, a1: 2,    sb: 32'h10,       nb: 2, wpb: 128, exp_code: 3'd0};
    tbl[1] = '{c0f: 99, c8f: 0, a1: 0,   sb: 32'h0,        nb: 1, wpb: 128, exp_code: 3'd1};
    tbl[2] = '{c0f: 1, c8f: 99, a1: 0,   sb: 32'h0,        nb: 1, wpb: 128, exp_code: 3'd2};
    tbl[3] = '{c0f: 0, c8f: 0, a1: 0,    sb: 32'h55,       nb: 0, wpb: 128, exp_code: 3'd0};
    tbl[4] = '{c0f: 0, c8f: 0, a1: 1,    sb: 32'h200,      nb: 2, wpb: 127, exp_code: 3'd5};
    tbl[5] = '{c0f: 0, c8f: 0, a1: 0,    sb: 32'hFFFFFFFF, nb: 2, wpb: 128, exp_code: 3'd0};
    tbl[6] = '{c0f: 3, c8f: 2, a1: 5,    sb: 32'h1234,     nb: 1, wpb: 128, exp_code: 3'd0};
    tbl[7] = '{c0f: 0, c8f: 0, a1: 5000, sb: 32'h0,        nb: 1, wpb: 128, exp_code: 3'd3};
    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 4; i++) begin
      vec_t rv;
      rv.c0f = int'($urandom_range(0, 4));
      rv.c8f = int'($urandom_range(0, 4));
      rv.a1  = int'($urandom_range(0, 6));
      rv.sb  = $urandom;
      rv.nb  = int'($urandom_range(1, 2));
      rv.wpb = 128;
      rv.exp_code = 3'd0;
      run_vec(rv, $sformatf("rnd%0d", i));
    end

    @(negedge clk) t_start = 1'b1;
    @(negedge clk) t_start = 1'b0;
    cyc = 0;
    while (!t_status[0] && cyc < 20) begin @(negedge clk); cyc++; end
    check("tmo_op_seen", t_status[0], 1'b1);
    n = 0;
    while (!t_berr && n < 300) begin @(negedge clk); n++; end
    check("tmo_cycles", n, 100);
    check("tmo_code", t_ecode, 3'd4);
    check("tmo_busy_op", {t_busy, t_status[0], t_bdone}, 3'b000);

    wpb = 128;  c0f = 0;  c8f = 0;  a1 = 0;  c0_seen = 0;  c8_seen = 0;  a_seen = 0;
    cmd_log.delete();  got_words.delete();
    start_block = 32'h40;  num_blocks = 16'd2;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (!(status[4] && got_words.size() >= 10) && cyc < 5000) begin @(negedge clk); cyc++; end
    check("midrd_reached", (cyc < 5000), 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("midrd_rst");
    @(negedge clk);
    check("midrd_no_strobe", wv, 1'b0);
    rst = 1'b0;
    run_vec(tbl[0], "restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
